// File: rtl/wptr_full.sv
// wptr_full -- write-side pointer and flag generator of the asynchronous FIFO.
// Lives entirely in the wclk domain. It owns the binary write pointer and
// exports its Gray form to the read domain. It brings the read Gray pointer
// in through a two-flop synchronizer and derives full, almost-full and level
// from it.
//
// Ports:
//   wclk          write clock (only clock)
//   wrst          synchronous active-high reset
//   winc          producer write request
//   rptr_gray     Gray read pointer from the read domain (async to wclk)
//   waddr         memory write address (low ADDR bits of the binary pointer)
//   wen           memory write enable, winc & ~wfull (combinational)
//   wptr_gray     registered Gray write pointer for the read domain
//   wfull         registered full flag
//   walmost_full  registered flag, occupancy >= af_level
//   wlevel        registered occupancy 0..depth as seen from the write side
module wptr_full #(
  parameter  int depth    = 16,
  parameter  int af_level = 14,
  localparam int ADDR     = $clog2(depth)
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic            winc,
  input  logic [ADDR:0]   rptr_gray,
  output logic [ADDR-1:0] waddr,
  output logic            wen,
  output logic [ADDR:0]   wptr_gray,
  output logic            wfull,
  output logic            walmost_full,
  output logic [ADDR:0]   wlevel
);

  localparam logic [ADDR:0] AF_LVL = (ADDR+1)'(af_level);

  logic [ADDR:0] rq1, rq2;
  logic [ADDR:0] rbin_s;
  logic [ADDR:0] wbin, wbin_next, wgray_next, lvl_next;
  logic          push;

  function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
    logic [ADDR:0] b;
    b[ADDR] = g[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    rbin_s     = gray2bin(rq2);
    push       = winc & ~wfull;
    wbin_next  = wbin + {{ADDR{1'b0}}, push};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    // Modular difference stays correct across pointer wrap; the stale rq2
    // can only make it larger than the true occupancy, never smaller.
    lvl_next   = wbin_next - rbin_s;
  end

  assign wen   = push;
  assign waddr = wbin[ADDR-1:0];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      rq1          <= '0;
      rq2          <= '0;
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      // Plain two-flop synchronizer: no logic between the stages.
      rq1          <= rptr_gray;
      rq2          <= rq1;
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      // Full: Gray pointers equal except the two top bits inverted.
      wfull        <= (wgray_next == {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]});
      wlevel       <= lvl_next;
      walmost_full <= (lvl_next >= AF_LVL);
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full: table-driven fill/overflow vectors, hand-written
// corner sequences, and randomized traffic against an occupancy model.
module tb_wptr_full;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int A     = 4;
  localparam int PMOD  = 32;

  logic         wclk = 1'b0;
  logic         wrst, winc;
  logic [A:0]   rptr_gray;
  logic [A-1:0] waddr;
  logic         wen, wfull, walmost_full;
  logic [A:0]   wptr_gray, wlevel;

  int checks = 0;
  int errors = 0;

  wptr_full #(.depth(DEPTH), .af_level(AFL)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .rptr_gray(rptr_gray),
    .waddr(waddr), .wen(wen), .wptr_gray(wptr_gray), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel)
  );

  always #5 wclk = ~wclk;

  // Model: count of accepted writes and the read pointers the write side
  // has seen (the read pointer used at an edge is the one driven two edges
  // earlier).
  int m_w = 0;
  bit m_full = 0;
  bit m_af = 0;
  int m_lvl = 0;
  int seen_new = 0, seen_old = 0;

  function automatic int gray(input int x);
    return (x ^ (x >> 1)) & (PMOD - 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input int rdp);
    if (r) begin
      m_w = 0; m_full = 0; m_af = 0; m_lvl = 0; seen_new = 0; seen_old = 0;
    end else begin
      if (w && !m_full) m_w = (m_w + 1) % PMOD;
      m_lvl    = (m_w - seen_old + PMOD) % PMOD;
      m_full   = (m_lvl == DEPTH);
      m_af     = (m_lvl >= AFL);
      seen_old = seen_new;
      seen_new = rdp;
    end
  endtask

  // One wclk cycle: drive at negedge, check wen, clock, check registered outputs.
  task automatic step(input bit r, input bit w, input int rdp);
    int rd;
    rd = rdp % PMOD;
    @(negedge wclk);
    wrst = r; winc = w; rptr_gray = 5'(gray(rd));
    #1 chk("wen", 32'(wen), 32'(w && !m_full));
    @(posedge wclk);
    model_edge(r, w, rd);
    #1;
    chk("waddr", 32'(waddr), 32'(m_w % DEPTH));
    chk("wptr_gray", 32'(wptr_gray), 32'(gray(m_w)));
    chk("wfull", 32'(wfull), 32'(m_full));
    chk("walmost_full", 32'(walmost_full), 32'(m_af));
    chk("wlevel", 32'(wlevel), 32'(m_lvl));
  endtask

  typedef struct {
    bit r; bit w; int rd;
    int addr; int gry; bit full; int lvl; bit af;
  } vec_t;
  vec_t tbl[21];

  initial begin
    bit saw_wrap;
    logic [A:0] prev_g;
    int rd;

    // Table: 2 reset edges with winc=1 and rptr_gray=00101 (binary 6),
    // 16 writes into an idle reader, then 3 writes while full.
    for (int i = 0; i < 2; i++) tbl[i] = '{1, 1, 6, 0, 0, 0, 0, 0};
    for (int k = 1; k <= 16; k++)
      tbl[k+1] = '{0, 1, 0, k % DEPTH, gray(k), k == DEPTH, k, k >= AFL};
    for (int i = 18; i < 21; i++) tbl[i] = '{0, 1, 0, 0, 5'b11000, 1, 16, 1};

    wrst = 1; winc = 0; rptr_gray = '0;
    @(posedge wclk);
    model_edge(1, 0, 0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rd);
      chk($sformatf("tbl%0d_waddr", i), 32'(waddr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_wptr_gray", i), 32'(wptr_gray), 32'(tbl[i].gry));
      chk($sformatf("tbl%0d_wfull", i), 32'(wfull), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_wlevel", i), 32'(wlevel), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_walmost_full", i), 32'(walmost_full), 32'(tbl[i].af));
    end

    // Read release: rptr moves to 1; visible exactly 3 edges later.
    step(0, 0, 1); chk("release_e1_wfull", 32'(wfull), 1);
    step(0, 0, 1); chk("release_e2_wfull", 32'(wfull), 1);
    chk("release_e2_wlevel", 32'(wlevel), 16);
    step(0, 0, 1); chk("release_e3_wfull", 32'(wfull), 0);
    chk("release_e3_wlevel", 32'(wlevel), 15);
    chk("release_waddr", 32'(waddr), 0);
    step(0, 1, 1); chk("refill_wfull", 32'(wfull), 1);
    chk("refill_wlevel", 32'(wlevel), 16);
    chk("refill_waddr", 32'(waddr), 1);

    // Wrap: write every other cycle, reader consumes everything written,
    // so level stays in 1..2 and the pointer wraps past 31.
    step(1, 0, 0);
    saw_wrap = 0;
    for (int i = 0; i < 80; i++) begin
      prev_g = wptr_gray;
      step(0, (i % 2) == 0, m_w);
      chk("wrap_gray_bits", 32'($countones(prev_g ^ wptr_gray)), 32'((i % 2) == 0));
      chk("wrap_wfull", 32'(wfull), 0);
      if (prev_g == 5'b10000 && wptr_gray == 5'b00000) saw_wrap = 1;
    end
    chk("wrap_seen", 32'(saw_wrap), 1);

    // Reset while full with a simultaneous write request.
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("pre_rst_wfull", 32'(wfull), 1);
    chk("pre_rst_wlevel", 32'(wlevel), 16);
    step(1, 1, 0);
    chk("midrst_waddr", 32'(waddr), 0);
    chk("midrst_wptr_gray", 32'(wptr_gray), 0);
    chk("midrst_wfull", 32'(wfull), 0);
    chk("midrst_walmost_full", 32'(walmost_full), 0);
    chk("midrst_wlevel", 32'(wlevel), 0);
    step(0, 1, 0);
    chk("resume_waddr", 32'(waddr), 1);
    chk("resume_wlevel", 32'(wlevel), 1);

    // Random traffic: phases alternate slow and fast readers so the FIFO
    // both fills up and drains. The reader never passes the written count.
    step(1, 0, 0);
    rd = 0;
    for (int i = 0; i < 600; i++) begin
      int pct;
      pct = ((i / 100) % 2) ? 15 : 75;
      if (rd != m_w && $urandom_range(99) < pct) rd = (rd + 1) % PMOD;
      step(0, $urandom_range(3) != 0, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
